// File: rtl/fixed_absmax_reduce_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : fixed_absmax_reduce_ctrl
// Description : Streaming absolute-maximum reduction controller. It takes
//               NUM_BEATS beats of IN_SIZE signed fixed-point lanes, finds the
//               element with the largest |x|, and returns that element's
//               original signed value. A result is held until it is accepted.
//
//               Tie handling: within a beat the lower lane wins. Across beats
//               the running value is replaced only on strictly greater
//               magnitude. The result is therefore the earliest element (in
//               arrival order) that has the maximum magnitude.
//
//               The most-negative code 2^(IN_WIDTH-1) has magnitude
//               2^(IN_WIDTH-1) as an unsigned value, which beats any positive.
//
// Ports       : clk            - clock, rising edge
//               rst            - synchronous active-high reset
//               data_in        - packed lanes, lane i at [i*IN_WIDTH +: IN_WIDTH]
//               data_in_valid  - upstream beat valid
//               data_in_ready  - beat can be accepted (depends on state only)
//               data_out       - signed value with largest magnitude
//               data_out_valid - data_out holds a completed block result
//               data_out_index - (ABSMAX_INDEX_EN only) beat*IN_SIZE + lane
//               data_out_ready - downstream accepts the result
//
// Options     : define ABSMAX_INDEX_EN to add the data_out_index output.
//
// Revision    : 1.0 - initial release
//==============================================================================
module fixed_absmax_reduce_ctrl #(
    parameter int IN_WIDTH  = 16,
    parameter int IN_SIZE   = 4,
    parameter int NUM_BEATS = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [IN_WIDTH*IN_SIZE-1:0]  data_in,
    input  logic                         data_in_valid,
    output logic                         data_in_ready,
    output logic [IN_WIDTH-1:0]          data_out,
    output logic                         data_out_valid,
`ifdef ABSMAX_INDEX_EN
    output logic [((NUM_BEATS*IN_SIZE) > 1 ? $clog2(NUM_BEATS*IN_SIZE) : 1)-1:0] data_out_index,
`endif
    input  logic                         data_out_ready
);

    localparam int c_CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(NUM_BEATS - 1);

    localparam logic [1:0] c_ST_FIRST = 2'd0;
    localparam logic [1:0] c_ST_ACCUM = 2'd1;
    localparam logic [1:0] c_ST_OUT   = 2'd2;

`ifdef ABSMAX_INDEX_EN
    localparam int c_IDX_W  = ((NUM_BEATS*IN_SIZE) > 1) ? $clog2(NUM_BEATS*IN_SIZE) : 1;
    localparam int c_LANE_W = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
`endif

    // Two's-complement magnitude as an unsigned value of the same width.
    function automatic logic [IN_WIDTH-1:0] f_mag(input logic [IN_WIDTH-1:0] x);
        return x[IN_WIDTH-1] ? ((~x) + IN_WIDTH'(1)) : x;
    endfunction

    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_beat_cnt;
    logic [IN_WIDTH-1:0] r_running;

    logic [IN_WIDTH-1:0] w_lane     [IN_SIZE];
    logic [IN_WIDTH-1:0] w_lane_mag [IN_SIZE];
    logic [IN_WIDTH-1:0] w_win;
    logic [IN_WIDTH-1:0] w_win_mag;
    logic [IN_WIDTH-1:0] w_run_mag;

`ifdef ABSMAX_INDEX_EN
    logic [c_IDX_W-1:0]  r_index;
    logic [c_LANE_W-1:0] w_win_lane;
    logic [c_IDX_W-1:0]  w_cand_index;
`endif

    generate
        for (genvar gi = 0; gi < IN_SIZE; gi++) begin : g_lane
            assign w_lane[gi]     = data_in[gi*IN_WIDTH +: IN_WIDTH];
            assign w_lane_mag[gi] = f_mag(w_lane[gi]);
        end
    endgenerate

    // Per-beat winner: purely combinational. A later lane only replaces the
    // current candidate on strictly greater magnitude, so lower lanes win ties.
    always_comb begin
        w_win     = w_lane[0];
        w_win_mag = w_lane_mag[0];
`ifdef ABSMAX_INDEX_EN
        w_win_lane = '0;
`endif
        for (int i = 1; i < IN_SIZE; i++) begin
            if (w_lane_mag[i] > w_win_mag) begin
                w_win     = w_lane[i];
                w_win_mag = w_lane_mag[i];
`ifdef ABSMAX_INDEX_EN
                w_win_lane = c_LANE_W'(i);
`endif
            end
        end
    end

    assign w_run_mag = f_mag(r_running);

`ifdef ABSMAX_INDEX_EN
    // beat_cnt is 0 in FIRST, so one expression serves both accumulating states.
    assign w_cand_index = (c_IDX_W'(r_beat_cnt) * c_IDX_W'(IN_SIZE)) + c_IDX_W'(w_win_lane);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_FIRST;
            r_beat_cnt <= '0;
            r_running  <= '0;
`ifdef ABSMAX_INDEX_EN
            r_index    <= '0;
`endif
        end else begin
            case (r_state)
                c_ST_FIRST: begin
                    if (data_in_valid) begin
                        r_running  <= w_win;
`ifdef ABSMAX_INDEX_EN
                        r_index    <= w_cand_index;
`endif
                        r_beat_cnt <= c_CNT_W'(1);
                        r_state    <= (NUM_BEATS == 1) ? c_ST_OUT : c_ST_ACCUM;
                    end
                end
                c_ST_ACCUM: begin
                    if (data_in_valid) begin
                        if (w_win_mag > w_run_mag) begin
                            r_running <= w_win;
`ifdef ABSMAX_INDEX_EN
                            r_index   <= w_cand_index;
`endif
                        end
                        // Leaving on the last beat keeps the counter in range.
                        if (r_beat_cnt == c_LAST_BEAT) begin
                            r_state <= c_ST_OUT;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + c_CNT_W'(1);
                        end
                    end
                end
                c_ST_OUT: begin
                    if (data_out_ready) begin
                        r_state    <= c_ST_FIRST;
                        r_beat_cnt <= '0;
                    end
                end
                default: begin
                    r_state    <= c_ST_FIRST;
                    r_beat_cnt <= '0;
                end
            endcase
        end
    end

    assign data_in_ready  = (r_state == c_ST_FIRST) || (r_state == c_ST_ACCUM);
    assign data_out_valid = (r_state == c_ST_OUT);
    assign data_out       = r_running;
`ifdef ABSMAX_INDEX_EN
    assign data_out_index = r_index;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fixed_absmax_reduce_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tb_fixed_absmax_reduce_ctrl
// Description : Self-checking bench for fixed_absmax_reduce_ctrl. Instance A
//               uses IN_SIZE=4, NUM_BEATS=3; instance B uses NUM_BEATS=1.
//               Expected block results are queued when a block is driven and
//               compared when the DUT presents and hands off its result.
//               Index checks compile in when ABSMAX_INDEX_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_fixed_absmax_reduce_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [63:0] din_a;
    logic        vin_a, rdy_a, vout_a, rout_a;
    logic [15:0] dout_a;
    logic [63:0] din_b;
    logic        vin_b, rdy_b, vout_b, rout_b;
    logic [15:0] dout_b;
`ifdef ABSMAX_INDEX_EN
    logic [3:0]  idx_a;
    logic [1:0]  idx_b;
`endif

    fixed_absmax_reduce_ctrl #(.IN_WIDTH(16), .IN_SIZE(4), .NUM_BEATS(3)) dut_a (
        .clk            (clk),
        .rst            (rst),
        .data_in        (din_a),
        .data_in_valid  (vin_a),
        .data_in_ready  (rdy_a),
        .data_out       (dout_a),
        .data_out_valid (vout_a),
`ifdef ABSMAX_INDEX_EN
        .data_out_index (idx_a),
`endif
        .data_out_ready (rout_a)
    );

    fixed_absmax_reduce_ctrl #(.IN_WIDTH(16), .IN_SIZE(4), .NUM_BEATS(1)) dut_b (
        .clk            (clk),
        .rst            (rst),
        .data_in        (din_b),
        .data_in_valid  (vin_b),
        .data_in_ready  (rdy_b),
        .data_out       (dout_b),
        .data_out_valid (vout_b),
`ifdef ABSMAX_INDEX_EN
        .data_out_index (idx_b),
`endif
        .data_out_ready (rout_b)
    );

    typedef struct {
        logic [15:0] v;
        int          idx;
    } exp_t;

    typedef struct {
        logic [2:0][63:0] b;
        logic [15:0]      v;
        int               idx;
    } vec_t;

    exp_t q[$];
    vec_t vt[8];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] p4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic int mag(input logic [15:0] x);
        int s;
        s = int'($signed(x));
        return (s < 0) ? -s : s;
    endfunction

    // Reference: scan elements in arrival order, replace only on strictly larger |x|.
    function automatic exp_t model(input logic [2:0][63:0] b);
        exp_t e;
        logic [15:0] x;
        e.v   = b[0][15:0];
        e.idx = 0;
        for (int bt = 0; bt < 3; bt++)
            for (int ln = 0; ln < 4; ln++) begin
                x = b[bt][ln*16 +: 16];
                if (mag(x) > mag(e.v)) begin
                    e.v   = x;
                    e.idx = bt*4 + ln;
                end
            end
        return e;
    endfunction

    // Scoreboard: a result is consumed when valid and ready are both high.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && vout_a && rout_a) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got output %h, required no pending result", dout_a);
            end else begin
                e = q.pop_front();
                chk("sb_data", 32'(dout_a), 32'(e.v));
`ifdef ABSMAX_INDEX_EN
                chk("sb_index", 32'(idx_a), 32'(e.idx));
`endif
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the handshake edge.
    task automatic send_beat(input logic [63:0] beat);
        bit r;
        bit done;
        done  = 1'b0;
        din_a = beat;
        vin_a = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            r = rdy_a;
            @(posedge clk);
            #1;
            if (r) done = 1'b1;
        end
        vin_a = 1'b0;
        chk("beat_accept", 32'(done), 32'd1);
    endtask

    // Idle gaps carry junk data with valid low; it must not be consumed.
    task automatic send_block(input logic [2:0][63:0] b, input int gap);
        for (int bt = 0; bt < 3; bt++) begin
            send_beat(b[bt]);
            for (int g = 0; g < gap; g++) begin
                din_a = p4(16'h7ABC, 16'h8001, 16'h7FFF, 16'h8000);
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        exp_t e;
        logic [2:0][63:0] rb;

        rst = 1'b1; vin_a = 1'b0; din_a = '0; rout_a = 1'b1;
        vin_b = 1'b0; din_b = '0; rout_b = 1'b1;

        vt[0] = '{b: {p4(-3,6,0,0), p4(4,0,-2,1), p4(1,-5,3,2)}, v: 16'd6, idx: 9};
        vt[1] = '{b: {p4(1,1,1,1), p4(3,0,0,0), p4(-7,2,0,0)}, v: 16'hFFF9, idx: 0};
        vt[2] = '{b: {p4(0,0,0,0), p4(1,'h8000,0,0), p4('h7FFF,0,0,0)}, v: 16'h8000, idx: 5};
        vt[3] = '{b: {p4(0,0,0,5), p4(-5,5,0,0), p4(5,-5,0,0)}, v: 16'd5, idx: 0};
        vt[4] = '{b: {p4(0,0,0,0), p4(0,0,0,0), p4(0,0,0,0)}, v: 16'd0, idx: 0};
        vt[5] = '{b: {p4(-1,-1,-1,-1), p4(-1,-1,-1,-1), p4(-1,-1,-1,-1)}, v: 16'hFFFF, idx: 0};
        vt[6] = '{b: {p4(0,0,0,'h7FFF), p4('h8000,0,0,0), p4(0,0,0,'h8000)}, v: 16'h8000, idx: 3};
        vt[7] = '{b: {p4(0,0,3,0), p4(0,-3,0,0), p4(2,0,0,0)}, v: 16'hFFFD, idx: 5};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_a", 32'(vout_a), 32'd0);
        chk("rst_data_a",  32'(dout_a), 32'd0);
        chk("rst_ready_a", 32'(rdy_a),  32'd1);
        chk("rst_valid_b", 32'(vout_b), 32'd0);
        chk("rst_ready_b", 32'(rdy_b),  32'd1);
`ifdef ABSMAX_INDEX_EN
        chk("rst_index_a", 32'(idx_a), 32'd0);
`endif
        rst = 1'b0;

        // Latency: valid exactly one cycle after the last handshake, then FIRST.
        q.push_back('{v: vt[0].v, idx: vt[0].idx});
        send_beat(vt[0].b[0]);
        send_beat(vt[0].b[1]);
        chk("lat_not_early", 32'(vout_a), 32'd0);
        send_beat(vt[0].b[2]);
        chk("lat_valid", 32'(vout_a), 32'd1);
        chk("lat_ready_low", 32'(rdy_a), 32'd0);
        @(posedge clk);
        #1;
        chk("back_first_valid", 32'(vout_a), 32'd0);
        chk("back_first_ready", 32'(rdy_a), 32'd1);

        // Table: alternate back-to-back and 1/0 valid toggling.
        for (int i = 1; i < 8; i++) begin
            q.push_back('{v: vt[i].v, idx: vt[i].idx});
            send_block(vt[i].b, i % 2);
        end

        // Backpressure: output held while a tempting beat is offered.
        rout_a = 1'b0;
        q.push_back('{v: vt[2].v, idx: vt[2].idx});
        send_block(vt[2].b, 0);
        din_a = p4(16'h7FFE, 0, 0, 0);
        vin_a = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(vout_a), 32'd1);
            chk("bp_data",  32'(dout_a), 32'h8000);
            chk("bp_ready", 32'(rdy_a),  32'd0);
        end
        rout_a = 1'b1;
        vin_a  = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_release_ready", 32'(rdy_a), 32'd1);
        chk("bp_release_valid", 32'(vout_a), 32'd0);

        // Reset mid-block discards the partial result.
        send_beat(p4(100, 0, 0, 0));
        send_beat(p4(0, 100, 0, 0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", 32'(vout_a), 32'd0);
        chk("midrst_ready", 32'(rdy_a),  32'd1);
        rst = 1'b0;
        q.push_back('{v: 16'd4, idx: 3});
        send_beat(p4(1, 2, 3, 4));
        chk("midrst_b1_valid", 32'(vout_a), 32'd0);
        send_beat(p4(1, 2, 3, 4));
        chk("midrst_b2_valid", 32'(vout_a), 32'd0);
        send_beat(p4(1, 2, 3, 4));
        chk("midrst_done", 32'(vout_a), 32'd1);

        // Random blocks against the reference model, with corner codes mixed in.
        for (int r = 0; r < 6; r++) begin
            for (int bt = 0; bt < 3; bt++)
                for (int ln = 0; ln < 4; ln++)
                    case ($urandom_range(0, 5))
                        0: rb[bt][ln*16 +: 16] = 16'h8000;
                        1: rb[bt][ln*16 +: 16] = 16'h7FFF;
                        2: rb[bt][ln*16 +: 16] = 16'($urandom_range(0, 7)) - 16'd4;
                        default: rb[bt][ln*16 +: 16] = 16'($urandom);
                    endcase
            e = model(rb);
            q.push_back(e);
            send_block(rb, int'($urandom_range(0, 2)));
        end

        // NUM_BEATS=1 instance: result one cycle after the only beat.
        din_b = p4(0, -9, 9, 8);
        vin_b = 1'b1;
        @(negedge clk);
        chk("b_ready", 32'(rdy_b), 32'd1);
        @(posedge clk);
        #1;
        vin_b = 1'b0;
        chk("b_valid", 32'(vout_b), 32'd1);
        chk("b_data",  32'(dout_b), 32'hFFF7);
`ifdef ABSMAX_INDEX_EN
        chk("b_index", 32'(idx_b), 32'd1);
`endif
        @(posedge clk);
        #1;
        chk("b_idle_valid", 32'(vout_b), 32'd0);
        chk("b_idle_ready", 32'(rdy_b),  32'd1);

        for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
        #1;
        chk("sb_drain", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
